// File: rtl/activation_scheduler.sv
// Shares one scalar activation unit across an N-lane packed vector: latches the
// vector, issues lanes one at a time over a start/done handshake, with a per-lane timeout.
module activation_scheduler #(
   parameter int unsigned S   = 32,
   parameter int unsigned N   = 4,
   parameter int unsigned TMO = 64
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           start,
   input  logic [S*N-1:0] x,
   output logic [S*N-1:0] y,
   output logic           done,
   output logic           busy,
   output logic           err,
   output logic           act_rst_n,
   output logic           act_start,
   output logic [S-1:0]   act_x,
   input  logic [S-1:0]   act_y,
   input  logic           act_done
);

   localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
   localparam int unsigned TW = $clog2(TMO + 1);
   localparam logic [S-1:0] QNAN = S'(32'h7fc00000);

   typedef enum logic [2:0] {
      StIdle,
      StIssue,
      StWait,
      StGap,
      StDone
   } state_e;

   state_e         state_q, state_d;
   logic [S*N-1:0] x_q, x_d;
   logic [S*N-1:0] y_q, y_d;
   logic [IW-1:0]  idx_q, idx_d;
   logic [TW-1:0]  tcnt_q, tcnt_d;
   logic           err_q, err_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         x_q     <= '0;
         y_q     <= '0;
         idx_q   <= '0;
         tcnt_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
         idx_q   <= idx_d;
         tcnt_q  <= tcnt_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      idx_d   = idx_q;
      tcnt_d  = tcnt_q;
      err_d   = err_q;
      unique case (state_q)
         StIdle, StDone: begin
            if (start) begin
               x_d     = x;
               idx_d   = '0;
               err_d   = 1'b0;
               state_d = StIssue;
            end
         end
         StIssue: begin
            tcnt_d  = '0;
            state_d = StWait;
         end
         StWait: begin
            tcnt_d = tcnt_q + TW'(1);
            // A completion arriving on the timeout cycle still counts as a real result.
            if (act_done || (tcnt_q == TW'(TMO - 1))) begin
               for (int i = 0; i < int'(N); i++) begin
                  if (idx_q == IW'(i)) begin
                     y_d[i*S +: S] = act_done ? act_y : QNAN;
                  end
               end
               if (!act_done) begin
                  err_d = 1'b1;
               end
               if (idx_q == IW'(N - 1)) begin
                  state_d = StDone;
               end else begin
                  idx_d   = idx_q + IW'(1);
                  state_d = StGap;
               end
            end
         end
         StGap: begin
            state_d = StIssue;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_comb begin
      act_x = '0;
      for (int i = 0; i < int'(N); i++) begin
         if (idx_q == IW'(i)) begin
            act_x = x_q[i*S +: S];
         end
      end
   end

   assign y         = y_q;
   assign err       = err_q;
   assign done      = (state_q == StDone);
   assign busy      = (state_q == StIssue) || (state_q == StWait) || (state_q == StGap);
   // The unit is held cleared everywhere except while a lane is in flight.
   assign act_rst_n = (state_q == StIssue) || (state_q == StWait);
   assign act_start = (state_q == StIssue);

endmodule

// File: tb/tb_activation_scheduler.sv
// Directed bench for activation_scheduler: a scalar unit model (y = x + 1.0 with
// per-lane latency) plus a timeline scoreboard checked on every falling edge.
module tb_activation_scheduler;

   localparam int S   = 32;
   localparam int N   = 4;
   localparam int TMO = 8;

   localparam logic [127:0] X1 = 128'h40800000_40400000_40000000_3f800000;
   localparam logic [127:0] Y1 = 128'h40a00000_40800000_40400000_40000000;
   localparam logic [127:0] X2 = 128'h41000000_40e00000_40c00000_40a00000;
   localparam logic [127:0] Y2 = 128'h41100000_41000000_40e00000_40c00000;
   localparam logic [127:0] Y1_TO = 128'h40a00000_40800000_7fc00000_40000000;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           start = 1'b0;
   logic [S*N-1:0] x = '0;
   logic [S*N-1:0] y;
   logic           done, busy, err;
   logic           act_rst_n, act_start;
   logic [S-1:0]   act_x;
   logic [S-1:0]   act_y = '0;
   logic           act_done = 1'b0;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   bit chk_en = 0;

   activation_scheduler #(.S(S), .N(N), .TMO(TMO)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .x         (x),
      .y         (y),
      .done      (done),
      .busy      (busy),
      .err       (err),
      .act_rst_n (act_rst_n),
      .act_start (act_start),
      .act_x     (act_x),
      .act_y     (act_y),
      .act_done  (act_done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [31:0] plus_one(input logic [31:0] v);
      case (v)
         32'h3f800000: return 32'h40000000;
         32'h40000000: return 32'h40400000;
         32'h40400000: return 32'h40800000;
         32'h40800000: return 32'h40a00000;
         32'h40a00000: return 32'h40c00000;
         32'h40c00000: return 32'h40e00000;
         32'h40e00000: return 32'h41000000;
         32'h41000000: return 32'h41100000;
         default:      return 32'hdeadbeef;
      endcase
   endfunction

   // Shared-unit model; k_cfg[lane] = cycles to completion, 0 = never completes.
   int k_cfg[N];
   int u_lane = 0;
   int u_cnt = 0;
   int u_k = 0;
   always @(posedge clk) begin
      if (!rst_n) u_lane <= 0;
      else if (act_rst_n && act_start) u_lane <= (u_lane + 1) % N;
      if (!act_rst_n) begin
         act_done <= 1'b0;
         u_cnt    <= 0;
      end else if (act_start) begin
         u_cnt    <= 1;
         u_k      <= k_cfg[u_lane];
         act_done <= (k_cfg[u_lane] == 1);
         act_y    <= plus_one(act_x);
      end else if (u_cnt != 0 && !act_done) begin
         u_cnt <= u_cnt + 1;
         if (u_cnt + 1 == u_k) act_done <= 1'b1;
      end
   end

   int st_total = 0;
   int lo_total = 0;
   always @(posedge clk) begin
      if (rst_n) begin
         if (act_start) st_total <= st_total + 1;
         if (busy && !act_rst_n) lo_total <= lo_total + 1;
      end
   end

   // Timeline model: lane i issues after edge s[i], is in flight through s[i]+kk[i],
   // and its result lands on edge s[i]+kk[i]+1.
   bit           have_run = 0;
   int           s_e[N];
   int           kk[N];
   bit           to[N];
   logic [31:0]  res[N];
   logic [127:0] xl = '0;
   logic [127:0] y_prev = '0;
   int           done_t = 0;

   function automatic logic [127:0] y_at(input int t);
      logic [127:0] v;
      v = y_prev;
      if (have_run)
         for (int i = 0; i < N; i++)
            if (t >= s_e[i] + kk[i] + 1) v[i*32 +: 32] = res[i];
      return v;
   endfunction

   function automatic bit err_at(input int t);
      bit e;
      e = 0;
      if (have_run)
         for (int i = 0; i < N; i++)
            if (to[i] && t >= s_e[i] + kk[i] + 1) e = 1;
      return e;
   endfunction

   always @(negedge clk) begin
      int t;
      bit es, er, axv;
      logic [31:0] ax;
      t = cyc;
      if (!rst_n) begin
         have_run = 0;
         y_prev   = '0;
         if (chk_en) begin
            chk("rst_done", done, 0);
            chk("rst_busy", busy, 0);
            chk("rst_act_start", act_start, 0);
            chk("rst_act_rst_n", act_rst_n, 0);
            chk("rst_y", y, 0);
            chk("rst_err", err, 0);
         end
      end else if (chk_en) begin
         es = 0; er = 0; axv = 0; ax = '0;
         if (have_run) begin
            for (int i = 0; i < N; i++) begin
               if (t == s_e[i]) es = 1;
               if (t >= s_e[i] && t <= s_e[i] + kk[i]) begin
                  er = 1; axv = 1; ax = xl[i*32 +: 32];
               end
            end
         end
         chk("done", done, have_run && t >= done_t);
         chk("busy", busy, have_run && t < done_t);
         chk("act_start", act_start, es);
         chk("act_rst_n", act_rst_n, er);
         chk("err", err, err_at(t));
         chk("y", y, y_at(t));
         if (axv) chk("act_x", act_x, ax);
         if (start && (!have_run || t >= done_t)) begin
            y_prev = y_at(t);
            xl = x;
            s_e[0] = t + 1;
            for (int i = 0; i < N; i++) begin
               to[i]  = (k_cfg[i] == 0) || (k_cfg[i] > TMO);
               kk[i]  = to[i] ? TMO : k_cfg[i];
               res[i] = to[i] ? 32'h7fc00000 : plus_one(x[i*32 +: 32]);
               if (i < N - 1) s_e[i+1] = s_e[i] + kk[i] + 2;
            end
            done_t = s_e[N-1] + kk[N-1] + 1;
            have_run = 1;
         end
      end
   end

   int c0 = 0;
   int st0 = 0;
   int lo0 = 0;

   task automatic set_k(input int k0, input int k1, input int k2, input int k3);
      k_cfg[0] = k0; k_cfg[1] = k1; k_cfg[2] = k2; k_cfg[3] = k3;
   endtask

   task automatic launch(input logic [127:0] xv);
      @(posedge clk);
      #1;
      x = xv;
      start = 1'b1;
      st0 = st_total;
      lo0 = lo_total;
      @(posedge clk);
      #1;
      start = 1'b0;
      x = {$urandom, $urandom, $urandom, $urandom};
      c0 = cyc;
   endtask

   task automatic wait_done(output int lat);
      int n;
      n = 0;
      @(negedge clk);
      while (!done && n < 200) begin
         @(negedge clk);
         n++;
      end
      lat = done ? (cyc - c0) : -1;
   endtask

   initial begin
      int lat;
      int n;
      set_k(3, 3, 3, 3);
      repeat (2) @(negedge clk);
      #1;
      rst_n = 1'b1;
      chk_en = 1;
      @(negedge clk);
      #1;
      chk("init_y", y, 0);
      chk("init_done", done, 0);
      chk("init_act_rst_n", act_rst_n, 0);

      // Four lanes, three-cycle unit.
      launch(X1);
      wait_done(lat);
      chk("a_latency", lat, 19);
      chk("a_y", y, Y1);
      chk("a_err", err, 0);
      chk("a_start_pulses", st_total - st0, 4);
      chk("a_gap_cycles", lo_total - lo0, 3);

      // Lane 1 never completes.
      set_k(3, 0, 3, 3);
      launch(X1);
      wait_done(lat);
      chk("b_latency", lat, 24);
      chk("b_y", y, Y1_TO);
      chk("b_err", err, 1);

      // Clean run clears err.
      set_k(3, 3, 3, 3);
      launch(X2);
      wait_done(lat);
      chk("c_latency", lat, 19);
      chk("c_y", y, Y2);
      chk("c_err", err, 0);

      // start during lane-0 WAIT with a different vector is ignored.
      launch(X1);
      @(posedge clk);
      @(posedge clk);
      #1;
      start = 1'b1;
      x = X2;
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_done(lat);
      chk("d_latency", lat, 19);
      chk("d_y", y, Y1);
      chk("d_start_pulses", st_total - st0, 4);

      // Completion coincides with the timeout on the last lane.
      set_k(3, 3, 3, TMO);
      launch(X2);
      wait_done(lat);
      chk("e_latency", lat, 24);
      chk("e_y", y, Y2);
      chk("e_err", err, 0);

      // Reset during lane-2 WAIT, then a full run.
      set_k(3, 3, 3, 3);
      launch(X1);
      n = 0;
      while (cyc < c0 + 12 && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("f_reach_wait", cyc, c0 + 12);
      chk("f_busy_before", busy, 1);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("f_act_start", act_start, 0);
      chk("f_act_rst_n", act_rst_n, 0);
      chk("f_y", y, 0);
      chk("f_done", done, 0);
      chk("f_busy", busy, 0);
      @(negedge clk);
      @(negedge clk);
      #1;
      rst_n = 1'b1;
      launch(X2);
      wait_done(lat);
      chk("g_latency", lat, 19);
      chk("g_y", y, Y2);
      chk("g_start_pulses", st_total - st0, 4);

      repeat (3) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/activation_scheduler.md
# activation_scheduler

Time-multiplexes one scalar floating-point activation unit (e.g. a single-lane `sigmoid`) across an N-lane packed vector. Rather than instantiating N activation datapaths, a neural-net layer uses this block. It latches the input vector, then issues one lane at a time to the shared unit over a start/done handshake. Each result is written into a packed output register. Lane-level timeout protection keeps a hung unit from stalling the layer.

## Interface
- `S`, 32, float width in bits.
- `N`, 4, number of lanes (≥1).
- `TMO`, 64, maximum WAIT cycles per lane before timeout (≥1).

Ports:
- `clk`, in, 1: clock; all state changes on posedge.
- `rst_n`, in, 1: reset; asynchronous, active-low.
- `start`, in, 1: request a new vector; sampled on posedge, accepted only in IDLE or DONE.
- `x`, in, S*N: input vector; lane i = `x[S*(i+1)-1:S*i]`, sampled on acceptance only.
- `y`, out, S*N: result vector register, same packing.
- `done`, out, 1: level, high in DONE state.
- `busy`, out, 1: high in ISSUE/WAIT/GAP.
- `err`, out, 1: sticky, at least one lane timed out in current/last run.
- `act_rst_n`, out, 1: shared-unit clear, low = unit held cleared.
- `act_start`, out, 1: shared-unit start pulse.
- `act_x`, out, S: operand to shared unit.
- `act_y`, in, S: result from shared unit.
- `act_done`, in, 1: shared-unit completion.

## Operation
- Registers:
  - `x_reg` (S*N)
  - `y` (S*N)
  - lane index `idx` (clog2(N), min 1 bit)
  - timeout counter `tcnt` (clog2(TMO+1))
  - `err`
  - state
- States:
  - IDLE: `start`=1 → latch `x` into `x_reg`, `idx`=0, `err`=0 → ISSUE.
  - ISSUE (1 cycle): `act_rst_n`=1, `act_start`=1, `tcnt`=0 → WAIT.
  - WAIT: `act_rst_n`=1, `act_start`=0, `tcnt`++.
    - If `act_done`=1: lane `idx` of `y` ← `act_y`.
    - Else if `tcnt`==TMO-1: lane `idx` of `y` ← 32'h7fc00000 (qNaN), `err`←1.
    - On either event: if `idx`==N-1 → DONE, else `idx`++ → GAP.
  - GAP (1 cycle): `act_rst_n`=0 (clears the unit's done/result), `act_start`=0 → ISSUE.
  - DONE: `done`=1, `act_rst_n`=0. `start`=1 behaves as in IDLE (re-run); otherwise remain.
- `act_x` = lane `idx` of `x_reg`, combinational mux; it is stable from ISSUE through WAIT.
- `act_rst_n`=0 and `act_start`=0 in IDLE, GAP and DONE.
- `start` during ISSUE/WAIT/GAP is ignored; `x` changes after acceptance have no effect.
- `act_done` outside WAIT is ignored. `act_done` and timeout in the same cycle → `act_done` wins (real result stored, no `err`).
- Lanes not yet written in a run hold their previous-run values; `y` is only valid when `done`=1.
- N=1: `idx` never increments; WAIT goes straight to DONE.

## Timing
- Reset (asynchronous, immediate):
  - state=IDLE
  - `y`=0, `x_reg`=0, `idx`=0, `tcnt`=0
  - `done`=0, `busy`=0, `err`=0
  - `act_start`=0, `act_rst_n`=0
- Reset asserted mid-run aborts the run immediately; the unit is cleared through `act_rst_n`=0.
- Start accepted at edge E → ISSUE during cycle E..E+1.
- If the unit raises `act_done` k cycles after ISSUE (k≥1, sampled on WAIT edges), a non-final lane takes k+2 cycles (ISSUE, k WAIT, GAP) and the final lane takes k+1.
- `done` rises after edge E + N(k+2) − 1. For N=4, k=3: 19 cycles.
- Timed-out lane: k is replaced by TMO.
- `done` falls on the edge that accepts a new `start`; `busy` rises on the same edge.

## Test plan
- Reset mid-WAIT (lane 2) → outputs immediately at reset values: `act_start`=0, `act_rst_n`=0, `y`=0, `done`=0. A new `start` after release runs all lanes normally.
- N=4, model unit y=x+1.0 with k=3; `x`={4.0,3.0,2.0,1.0} (32'h40800000,40400000,40000000,3f800000) → `y`={5.0,4.0,3.0,2.0}, `done` after 19 cycles.
  - Check `act_start` pulses exactly 4 times.
  - Check `act_rst_n` low for exactly 1 cycle between lanes.
- Model never asserts `act_done` on lane 1 only, TMO=8 → lane 1 = 32'h7fc00000, `err`=1, other lanes correct.
  - Check `done` after 3·5+(8+2)−1 = 24 cycles.
  - A subsequent clean run clears `err`.
- `start` pulsed during WAIT of lane 0 with a different `x` → ignored; results match the originally latched vector; `act_start` count stays 4.
- `act_done` and timeout coincide on lane 3 (`act_done` at WAIT cycle TMO) → real result stored, `err`=0.
